// File: rtl/fetch_prefetch_imem.sv
// Instruction memory with a sequential fetch unit and a prefetch FIFO feeding decode.
// Fetch faults (misaligned or out-of-range PC) push one NOP fault entry and stop fetch until a redirect.
module fetch_prefetch_imem #(
    parameter int unsigned NUM_INSTR  = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                                  clk,
    input  logic                                  n_rst,
    input  logic                                  redirect_valid,
    input  logic [31:0]                           redirect_pc,
    input  logic                                  load_en,
    input  logic [31:0]                           load_addr,
    input  logic [31:0]                           load_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [31:0]                           out_instr,
    output logic [31:0]                           out_pc,
    output logic                                  out_fault,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count
);

    localparam int unsigned AW = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    logic [31:0] r_mem        [NUM_INSTR];
    logic [31:0] r_fifo_instr [FIFO_DEPTH];
    logic [31:0] r_fifo_pc    [FIFO_DEPTH];
    logic        r_fifo_fault [FIFO_DEPTH];

    state_t        r_state;
    state_t        w_state_nx;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_nx;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] w_wr_ptr_nx;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_rd_ptr_nx;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nx;

    logic          w_pop;
    logic          w_issue;
    logic          w_run;
    logic          w_full;
    logic          w_fault;
    logic          w_load_ok;
    logic [AW-1:0] w_mem_idx;
    logic [31:0]   w_rd_word;

    // Fetch address decode, load qualification and FIFO status
    always_comb begin
        w_fault   = (r_pc[1:0] != 2'b00) || (r_pc[31:2] >= 30'(NUM_INSTR));
        w_mem_idx = r_pc[AW+1:2];
        w_rd_word = r_mem[w_mem_idx];
        w_load_ok = load_en && (load_addr[1:0] == 2'b00) &&
                    (load_addr[31:2] < 30'(NUM_INSTR));
        w_full    = (r_count == CW'(FIFO_DEPTH));
        w_pop     = (r_count != CW'(0)) && out_ready;
    end

    // FIFO head presented to decode; zero while empty
    always_comb begin
        out_valid  = (r_count != CW'(0));
        fifo_count = r_count;
        if (out_valid) begin
            out_instr = r_fifo_instr[r_rd_ptr];
            out_pc    = r_fifo_pc[r_rd_ptr];
            out_fault = r_fifo_fault[r_rd_ptr];
        end else begin
            out_instr = 32'h0000_0000;
            out_pc    = 32'h0000_0000;
            out_fault = 1'b0;
        end
    end

    // Next-state logic: redirect flushes and wins, load steals the issue slot
    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_wr_ptr_nx = r_wr_ptr;
        w_rd_ptr_nx = r_rd_ptr;
        w_count_nx  = r_count;
        w_issue     = 1'b0;

        case (r_state)
            ST_RUN:  w_run = 1'b1;
            ST_HALT: w_run = 1'b0;
            default: w_run = 1'b0;
        endcase

        if (redirect_valid) begin
            w_state_nx  = ST_RUN;
            w_pc_nx     = redirect_pc;
            w_wr_ptr_nx = PW'(0);
            w_rd_ptr_nx = PW'(0);
            w_count_nx  = CW'(0);
        end else begin
            w_issue = w_run && !load_en && (!w_full || w_pop);
            if (w_issue) begin
                w_wr_ptr_nx = r_wr_ptr + PW'(1);
                if (w_fault) begin
                    w_state_nx = ST_HALT;
                end else begin
                    w_pc_nx = r_pc + 32'd4;
                end
            end else begin
                w_wr_ptr_nx = r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_ptr_nx = r_rd_ptr + PW'(1);
            end else begin
                w_rd_ptr_nx = r_rd_ptr;
            end
            case ({w_issue, w_pop})
                2'b10:   w_count_nx = r_count + CW'(1);
                2'b01:   w_count_nx = r_count - CW'(1);
                default: w_count_nx = r_count;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            r_wr_ptr <= PW'(0);
            r_rd_ptr <= PW'(0);
            r_count  <= CW'(0);
        end else begin
            r_state  <= w_state_nx;
            r_pc     <= w_pc_nx;
            r_wr_ptr <= w_wr_ptr_nx;
            r_rd_ptr <= w_rd_ptr_nx;
            r_count  <= w_count_nx;
        end
    end

    // FIFO entry write; the memory read happens on the same edge as the push
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_fifo_instr[r_wr_ptr] <= w_fault ? NOP_INSTR : w_rd_word;
            r_fifo_pc[r_wr_ptr]    <= r_pc;
            r_fifo_fault[r_wr_ptr] <= w_fault;
        end
    end

    // Program-load port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem[load_addr[AW+1:2]] <= load_data;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_imem.sv
// Directed bench for fetch_prefetch_imem: vector table plus hand sequences for load and reset.
module tb_fetch_prefetch_imem;

    localparam logic [31:0] A_BASE = 32'hA000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        n_rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;
    logic [2:0]  fifo_count;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        ld;
        logic [31:0] laddr;
        logic [31:0] ldata;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        logic        ef;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t vecs[$];

    fetch_prefetch_imem #(
        .NUM_INSTR (32),
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_fault     (out_fault),
        .fifo_count    (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] aw(input int i);
        return A_BASE + 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic redir, input logic [31:0] rpc, input logic ld,
                       input logic [31:0] laddr, input logic [31:0] ldata, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                       input logic ef, input logic [2:0] ecnt);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.ld = ld; v.laddr = laddr; v.ldata = ldata;
        v.rdy = rdy; v.ev = ev; v.epc = epc; v.ein = ein; v.ef = ef; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    // Drive at negedge, let one rising edge pass, sample at the following negedge
    task automatic step(input logic redir, input logic [31:0] rpc, input logic ld,
                        input logic [31:0] laddr, input logic [31:0] ldata, input logic rdy);
        redirect_valid = redir;
        redirect_pc    = rpc;
        load_en        = ld;
        load_addr      = laddr;
        load_data      = ldata;
        out_ready      = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_rst = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        load_en = 1'b0; load_addr = 32'h0; load_data = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_fault", 32'(out_fault), 32'h0);

        // Fill memory; loads block issue so the FIFO stays empty throughout
        load_en = 1'b1; load_addr = 32'h0; load_data = aw(0);
        n_rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 32'h0, 1'b1, 32'(i * 4), aw(i), 1'b0);
            chk("load_count", 32'(fifo_count), 32'h0);
        end

        // Streaming from 0
        add(1, 32'h00, 0, 0, 0, 1,  0, 32'h00, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 1,       1, 32'h00, aw(0), 0, 3'd1);
        add(0, 0, 0, 0, 0, 1,       1, 32'h04, aw(1), 0, 3'd1);
        add(0, 0, 0, 0, 0, 1,       1, 32'h08, aw(2), 0, 3'd1);
        add(0, 0, 0, 0, 0, 1,       1, 32'h0C, aw(3), 0, 3'd1);
        // Back-pressure until full, then release
        add(1, 32'h00, 0, 0, 0, 0,  0, 32'h00, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 0,       1, 32'h00, aw(0), 0, 3'd1);
        add(0, 0, 0, 0, 0, 0,       1, 32'h00, aw(0), 0, 3'd2);
        add(0, 0, 0, 0, 0, 0,       1, 32'h00, aw(0), 0, 3'd3);
        add(0, 0, 0, 0, 0, 0,       1, 32'h00, aw(0), 0, 3'd4);
        add(0, 0, 0, 0, 0, 0,       1, 32'h00, aw(0), 0, 3'd4);
        add(0, 0, 0, 0, 0, 1,       1, 32'h04, aw(1), 0, 3'd4);
        add(0, 0, 0, 0, 0, 1,       1, 32'h08, aw(2), 0, 3'd4);
        add(0, 0, 0, 0, 0, 1,       1, 32'h0C, aw(3), 0, 3'd4);
        add(0, 0, 0, 0, 0, 1,       1, 32'h10, aw(4), 0, 3'd4);
        add(0, 0, 0, 0, 0, 1,       1, 32'h14, aw(5), 0, 3'd4);
        // Flush a full FIFO
        add(1, 32'h40, 0, 0, 0, 1,  0, 32'h00, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 0,       1, 32'h40, aw(16), 0, 3'd1);
        // Misaligned redirect faults and halts
        add(1, 32'h02, 0, 0, 0, 0,  0, 32'h00, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 0,       1, 32'h02, NOP, 1, 3'd1);
        add(0, 0, 0, 0, 0, 1,       0, 32'h00, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 1,       0, 32'h00, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 1,       0, 32'h00, 0, 0, 3'd0);
        // Sequential run off the end of memory
        add(1, 32'h78, 0, 0, 0, 1,  0, 32'h00, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 1,       1, 32'h78, aw(30), 0, 3'd1);
        add(0, 0, 0, 0, 0, 1,       1, 32'h7C, aw(31), 0, 3'd1);
        add(0, 0, 0, 0, 0, 1,       1, 32'h80, NOP, 1, 3'd1);
        add(0, 0, 0, 0, 0, 1,       0, 32'h00, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 1,       0, 32'h00, 0, 0, 3'd0);
        // Redirect together with load, then load stealing the issue slot
        add(1, 32'h10, 1, 32'h10, 32'hDEAD_BEEF, 1, 0, 32'h00, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 1,       1, 32'h10, 32'hDEAD_BEEF, 0, 3'd1);
        add(0, 0, 0, 0, 0, 1,       1, 32'h14, aw(5), 0, 3'd1);
        add(0, 0, 1, 32'h14, 32'h1111_2222, 1, 0, 32'h00, 0, 0, 3'd0);
        add(0, 0, 0, 0, 0, 1,       1, 32'h18, aw(6), 0, 3'd1);

        foreach (vecs[k]) begin
            step(vecs[k].redir, vecs[k].rpc, vecs[k].ld, vecs[k].laddr, vecs[k].ldata, vecs[k].rdy);
            chk($sformatf("v%0d_count", k), 32'(fifo_count), 32'(vecs[k].ecnt));
            chk($sformatf("v%0d_valid", k), 32'(out_valid), 32'(vecs[k].ev));
            if (vecs[k].ev) begin
                chk($sformatf("v%0d_pc", k), out_pc, vecs[k].epc);
                chk($sformatf("v%0d_instr", k), out_instr, vecs[k].ein);
                chk($sformatf("v%0d_fault", k), 32'(out_fault), 32'(vecs[k].ef));
            end
        end

        // Async reset with three entries queued
        step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("pre_rst_count", 32'(fifo_count), 32'h3);
        n_rst = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_count", 32'(fifo_count), 32'h0);
        load_en = 1'b1; load_addr = 32'h81; load_data = 32'hFFFF_FFFF;
        @(negedge clk);
        n_rst = 1'b1;
        step(1'b0, 32'h0, 1'b1, 32'h81, 32'hFFFF_FFFF, 1'b0);
        chk("ld81_count", 32'(fifo_count), 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'h84, 32'hFFFF_FFFF, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h05, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("post_rst_redir_count", 32'(fifo_count), 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("retain_pc0", out_pc, 32'h0);
        chk("retain_instr0", out_instr, aw(0));
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("retain_instr1", out_instr, aw(1));
        step(1'b1, 32'h78, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("retain_instr30", out_instr, aw(30));
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("retain_instr31", out_instr, aw(31));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
